// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-port synchronous memory between a CPU and a DMA engine.
// The CPU normally wins when both ask in the same cycle. The DMA engine
// counts how many cycles in a row it has been refused. Once that count
// reaches MAX_WAIT, the arbiter switches to DMA priority for exactly one
// cycle. Grants are combinational, so a winning request is serviced in the
// same cycle it is presented. Read data returns one cycle later and is
// routed to whichever requester owned that earlier read.
//
// Parameters
//   MAX_WAIT    consecutive DMA refusals before the DMA takes priority (1..15)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   cpu_req     CPU access request (held until cpu_gnt)
//   cpu_we      CPU write (1) / read (0)
//   cpu_addr    CPU byte address
//   cpu_wdata   CPU write data
//   cpu_gnt     CPU request accepted this cycle
//   cpu_rvalid  CPU read data valid (one cycle after a granted CPU read)
//   cpu_rdata   CPU read data, zero when cpu_rvalid is low
//   dma_*       same meanings as the CPU ports, for the DMA engine
//   mem_addr    memory address, taken from the granted requester
//   mem_we      memory write enable, low whenever nothing is granted
//   mem_wdata   memory write data, taken from the granted requester
//   mem_rdata   memory read data, valid one cycle after the address
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,

    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,

    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [0:0] {
        CPU_PRI = 1'b0,
        DMA_PRI = 1'b1
    } pri_state_t;

    // The wait counter is 4 bits wide, so MAX_WAIT must stay within 1..15.
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    pri_state_t  state;
    logic [3:0]  wait_cnt;
    logic [3:0]  wait_inc;
    logic        dma_refused;
    logic        rd_owner_cpu;
    logic        rd_owner_dma;

    // Arbitration. The DMA wins if it is alone, or if it has earned priority.
    // Everything else that asks goes to the CPU. Both grants are gated by
    // rst_n, so nothing reaches the memory while reset is held, even
    // between clock edges.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (rst_n) begin
            if (dma_req && (state == DMA_PRI || !cpu_req)) begin
                dma_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    // The memory command comes from whichever side won this cycle. The
    // address and write data only matter when a grant is issued, so the
    // mux can default to the CPU fields.
    always_comb begin
        mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
        mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
        mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    end

    assign dma_refused = dma_req & ~dma_gnt;
    assign wait_inc    = wait_cnt + 4'd1;

    // Priority FSM, refusal counter and read-ownership flags.
    // - The counter tracks consecutive refusals and clears as soon as the
    //   DMA is served or stops asking.
    // - The switch to DMA_PRI happens on the edge where the counter reaches
    //   the limit. DMA_PRI always lasts a single cycle: either the DMA is
    //   granted or it has dropped its request. In both cases priority goes
    //   back to the CPU.
    // - The owner flags remember who issued the read being returned by the
    //   memory in the next cycle. Because they are cleared by reset, a read
    //   in flight when reset asserts is simply dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CPU_PRI;
            wait_cnt     <= 4'd0;
            rd_owner_cpu <= 1'b0;
            rd_owner_dma <= 1'b0;
        end else begin
            rd_owner_cpu <= cpu_gnt & ~cpu_we;
            rd_owner_dma <= dma_gnt & ~dma_we;

            if (dma_refused) begin
                wait_cnt <= wait_inc;
            end else begin
                wait_cnt <= 4'd0;
            end

            case (state)
                CPU_PRI: begin
                    if (dma_refused && wait_inc == WAIT_LIMIT) begin
                        state <= DMA_PRI;
                    end
                end
                DMA_PRI: begin
                    state <= CPU_PRI;
                end
                default: begin
                    state <= CPU_PRI;
                end
            endcase
        end
    end

    // The read response goes to the previous cycle's owner, regardless of
    // what is being granted now. The non-owner sees zero data.
    always_comb begin
        cpu_rvalid = rd_owner_cpu;
        dma_rvalid = rd_owner_dma;
        cpu_rdata  = rd_owner_cpu ? mem_rdata : 32'd0;
        dma_rdata  = rd_owner_dma ? mem_rdata : 32'd0;
    end

    // Structural sanity properties: one grant at most, and no memory write
    // without a grant behind it.
    a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
        !(cpu_gnt && dma_gnt));

    a_we_needs_gnt: assert property (@(posedge clk) disable iff (!rst_n)
        mem_we |-> (cpu_gnt || dma_gnt));

    a_single_owner: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_owner_cpu && rd_owner_dma));

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Drives mem_arbiter (MAX_WAIT = 4) against a small behavioural memory.
// Directed scenarios cover reset, a lone read, contention, a DMA write,
// response overlap, reset during a read and a DMA drop-out. A randomized
// run is then compared against a refusal-count reference model that keeps
// a shadow copy of the memory contents.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid;
    logic [31:0] dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Initial memory image. Word 0x40 (byte address 0x100) holds 0xDEADBEEF.
    function automatic logic [31:0] init_word(int i);
        if (i == 'h40) return 32'hDEADBEEF;
        return 32'(i) * 32'h9E3779B1 + 32'h13579BDF;
    endfunction

    // 256-word synchronous memory. Read data appears one cycle after the
    // address. It loads its image on the first clock edge, while reset is
    // still held.
    logic [31:0] mem [0:255];
    bit mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
            mem_rdata <= mem[mem_addr[9:2]];
        end
    end

    // Shadow of what the memory should contain, maintained by the bench.
    logic [31:0] ref_mem [0:255];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;  cpu_wdata = 32'h0;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h4;  dma_wdata = 32'hA5A5A5A5;
        repeat (3) tick();
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_cpu_gnt: got %b expected 0", cpu_gnt); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("[TB] FAIL reset_dma_gnt: got %b expected 0", dma_gnt); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid: got %b/%b expected 0/0", cpu_rvalid, dma_rvalid); end
        checks++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", cpu_rdata, dma_rdata); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("[TB] FAIL first_cycle_grant: got cpu=%b dma=%b expected cpu=1 dma=0", cpu_gnt, dma_gnt); end
        tick();
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== ref_mem[0]) begin errors++; $display("[TB] FAIL first_cycle_read: got v=%b d=%h expected v=1 d=%h", cpu_rvalid, cpu_rdata, ref_mem[0]); end
        tick();
        idle();
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1 || dma_gnt !== 1'b0) begin errors++; $display("[TB] FAIL lone_read_gnt: got cpu=%b dma=%b expected 1/0", cpu_gnt, dma_gnt); end
        checks++; if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL lone_read_mem: got addr=%h we=%b expected 100/0", mem_addr, mem_we); end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL lone_read_data: got v=%b d=%h expected 1/deadbeef", cpu_rvalid, cpu_rdata); end
        checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0) begin errors++; $display("[TB] FAIL lone_read_other: got v=%b d=%h expected 0/0", dma_rvalid, dma_rdata); end
        idle();
    endtask

    task automatic test_contention();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h300;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (cpu_gnt !== (c != 4) || dma_gnt !== (c == 4)) begin
                errors++; $display("[TB] FAIL contention_c%0d: got cpu=%b dma=%b expected cpu=%b dma=%b", c, cpu_gnt, dma_gnt, c != 4, c == 4);
            end
            if (c == 5) begin
                checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== ref_mem[8'hC0]) begin errors++; $display("[TB] FAIL contention_dma_data: got v=%b d=%h expected 1/%h", dma_rvalid, dma_rdata, ref_mem[8'hC0]); end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_dma_write();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h12345678;
        @(negedge clk);
        checks++; if (dma_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin errors++; $display("[TB] FAIL dma_write_gnt: got dma=%b cpu=%b expected 1/0", dma_gnt, cpu_gnt); end
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h40) begin errors++; $display("[TB] FAIL dma_write_mem: got we=%b a=%h d=%h expected 1/40/12345678", mem_we, mem_addr, mem_wdata); end
        ref_mem[8'h10] = 32'h12345678;
        tick();
        dma_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        @(negedge clk);
        checks++; if (dma_rvalid !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL dma_write_no_rvalid: got dma=%b cpu=%b expected 0/0", dma_rvalid, cpu_rvalid); end
        tick();
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL dma_write_readback: got v=%b d=%h expected 1/12345678", cpu_rvalid, cpu_rdata); end
        idle();
    endtask

    task automatic test_overlap();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        @(negedge clk);
        checks++; if (cpu_gnt !== 1'b1) begin errors++; $display("[TB] FAIL overlap_cpu_gnt: got %b expected 1", cpu_gnt); end
        tick();
        cpu_req = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
        @(negedge clk);
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("[TB] FAIL overlap_dma_gnt: got %b expected 1", dma_gnt); end
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== ref_mem[8'h40] || dma_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL overlap_c1: got cv=%b cd=%h dv=%b expected 1/%h/0", cpu_rvalid, cpu_rdata, dma_rvalid, ref_mem[8'h40]); end
        tick();
        dma_req = 1'b0;
        @(negedge clk);
        checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== ref_mem[8'h20]) begin errors++; $display("[TB] FAIL overlap_dma_data: got v=%b d=%h expected 1/%h", dma_rvalid, dma_rdata, ref_mem[8'h20]); end
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL overlap_c2_cpu: got v=%b d=%h expected 0/0", cpu_rvalid, cpu_rdata); end
        idle();
    endtask

    task automatic test_reset_mid_read();
        // Four refused DMA cycles leave the arbiter about to favour the DMA,
        // with a CPU read in flight when reset hits.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h104;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h108;
        repeat (4) tick();
        rst_n = 1'b0;
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL midreset_rvalid: got v=%b d=%h expected 0/0", cpu_rvalid, cpu_rdata); end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_after: got cpu=%b dma=%b expected 0/0", cpu_rvalid, dma_rvalid); end
        tick();
        // Priority and counter must be back at their reset values: a full
        // contention sequence is needed again before the DMA wins.
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (cpu_gnt !== (c != 4) || dma_gnt !== (c == 4)) begin
                errors++; $display("[TB] FAIL midreset_contention_c%0d: got cpu=%b dma=%b expected cpu=%b dma=%b", c, cpu_gnt, dma_gnt, c != 4, c == 4);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_dropout();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
        dma_we = 1'b0; dma_addr = 32'h20;
        for (int c = 0; c < 9; c++) begin
            dma_req = (c != 3);
            @(negedge clk);
            checks++;
            if (cpu_gnt !== (c != 8) || dma_gnt !== (c == 8)) begin
                errors++; $display("[TB] FAIL dropout_c%0d: got cpu=%b dma=%b expected cpu=%b dma=%b", c, cpu_gnt, dma_gnt, c != 8, c == 8);
            end
            tick();
        end
        idle();
    endtask

    // Reference model: the DMA wins when it is alone, or once it has been
    // refused MAX_WAIT times in a row. Read results come from the shadow
    // memory and are expected back on the next cycle for the same requester.
    task automatic test_random();
        int          refusals = 0;
        bit          cpu_pend = 1'b0, dma_pend = 1'b0;
        bit          rsp_cpu = 1'b0, rsp_dma = 1'b0;
        logic [31:0] rsp_data = 32'h0;
        bit          exp_dma, exp_cpu, exp_we;
        logic [31:0] exp_addr, exp_wdata;
        for (int n = 0; n < 600; n++) begin
            if (!cpu_pend && $urandom_range(99) < 60) begin
                cpu_pend  = 1'b1;
                cpu_we    = $urandom_range(1);
                cpu_addr  = {22'd0, 8'($urandom_range(255)), 2'b00};
                cpu_wdata = $urandom;
            end
            if (!dma_pend && $urandom_range(99) < 55) begin
                dma_pend  = 1'b1;
                dma_we    = $urandom_range(1);
                dma_addr  = {22'd0, 8'($urandom_range(255)), 2'b00};
                dma_wdata = $urandom;
            end else if (dma_pend && $urandom_range(99) < 5) begin
                dma_pend = 1'b0;
            end
            cpu_req = cpu_pend;
            dma_req = dma_pend;

            exp_dma   = dma_pend && (!cpu_pend || refusals >= MAX_WAIT);
            exp_cpu   = cpu_pend && !exp_dma;
            exp_we    = exp_dma ? dma_we : (exp_cpu ? cpu_we : 1'b0);
            exp_addr  = exp_dma ? dma_addr : cpu_addr;
            exp_wdata = exp_dma ? dma_wdata : cpu_wdata;

            @(negedge clk);
            checks++; if (cpu_gnt !== exp_cpu || dma_gnt !== exp_dma) begin errors++; $display("[TB] FAIL rand_gnt n=%0d: got cpu=%b dma=%b expected cpu=%b dma=%b", n, cpu_gnt, dma_gnt, exp_cpu, exp_dma); end
            checks++; if (mem_we !== exp_we) begin errors++; $display("[TB] FAIL rand_we n=%0d: got %b expected %b", n, mem_we, exp_we); end
            if (exp_cpu || exp_dma) begin
                checks++; if (mem_addr !== exp_addr) begin errors++; $display("[TB] FAIL rand_addr n=%0d: got %h expected %h", n, mem_addr, exp_addr); end
            end
            if (exp_we) begin
                checks++; if (mem_wdata !== exp_wdata) begin errors++; $display("[TB] FAIL rand_wdata n=%0d: got %h expected %h", n, mem_wdata, exp_wdata); end
            end
            checks++; if (cpu_rvalid !== rsp_cpu || cpu_rdata !== (rsp_cpu ? rsp_data : 32'h0)) begin errors++; $display("[TB] FAIL rand_cpu_rsp n=%0d: got v=%b d=%h expected v=%b d=%h", n, cpu_rvalid, cpu_rdata, rsp_cpu, rsp_cpu ? rsp_data : 32'h0); end
            checks++; if (dma_rvalid !== rsp_dma || dma_rdata !== (rsp_dma ? rsp_data : 32'h0)) begin errors++; $display("[TB] FAIL rand_dma_rsp n=%0d: got v=%b d=%h expected v=%b d=%h", n, dma_rvalid, dma_rdata, rsp_dma, rsp_dma ? rsp_data : 32'h0); end

            rsp_cpu  = exp_cpu && !cpu_we;
            rsp_dma  = exp_dma && !dma_we;
            rsp_data = ref_mem[exp_addr[9:2]];
            if (exp_we) ref_mem[exp_addr[9:2]] = exp_wdata;
            refusals = (dma_pend && !exp_dma) ? refusals + 1 : 0;
            if (exp_cpu) cpu_pend = 1'b0;
            if (exp_dma) dma_pend = 1'b0;
            tick();
        end
        idle();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_cpu_read();
        test_contention();
        test_dma_write();
        test_overlap();
        test_reset_mid_read();
        test_dropout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
